// File: rtl/tdm_demux4_if.sv
// tdm_demux4_if: link between a TDM sample source and the 4-lane demultiplexer.
//   master: drives din/din_valid/sof, observes the rebuilt lanes and status.
//   slave : receives the serial stream, drives a..d, frame_valid, frame_err,
//           slot and locked.
interface tdm_demux4_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             sof;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic             frame_valid;
  logic             frame_err;
  logic [1:0]       slot;
  logic             locked;

  modport master (
    output din, din_valid, sof,
    input  a, b, c, d, frame_valid, frame_err, slot, locked
  );

  modport slave (
    input  din, din_valid, sof,
    output a, b, c, d, frame_valid, frame_err, slot, locked
  );
endinterface

// File: rtl/tdm_demux4.sv
// tdm_demux4: rebuilds four parallel lanes (a..d) from a serial TDM stream
// whose slots 0..3 carry channels a, b, c, d. Lanes update together once per
// complete frame; framing errors (early or missing sof) pulse frame_err.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - tdm_demux4_if.slave: din/din_valid/sof in; a..d, frame_valid,
//          frame_err, slot (next expected slot), locked (in RUN) out
module tdm_demux4 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  tdm_demux4_if.slave  bus
);

  localparam int unsigned SLOT_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [WIDTH-1:0]  sh0_q, sh1_q, sh2_q;
  logic [WIDTH-1:0]  sh0_d, sh1_d, sh2_d;
  logic [WIDTH-1:0]  a_q, b_q, c_q, d_q;
  logic [WIDTH-1:0]  a_d, b_d, c_d, d_d;
  logic              fv_q, fv_d;
  logic              fe_q, fe_d;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      slot_q  <= '0;
      sh0_q   <= '0;
      sh1_q   <= '0;
      sh2_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      fv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
      sh2_q   <= sh2_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      fv_q    <= fv_d;
      fe_q    <= fe_d;
    end
  end

  // Next state: sof always (re)enters RUN; a non-sof sample at slot 0 drops lock
  always_comb begin
    state_d = state_q;
    if (bus.din_valid) begin
      if (bus.sof) begin
        state_d = RUN;
      end else if (state_q == RUN && slot_q == SLOT_W'(0)) begin
        state_d = IDLE;
      end
    end
  end

  // Next values for slot, shadow, lanes and pulses
  always_comb begin
    slot_d = slot_q;
    sh0_d  = sh0_q;
    sh1_d  = sh1_q;
    sh2_d  = sh2_q;
    a_d    = a_q;
    b_d    = b_q;
    c_d    = c_q;
    d_d    = d_q;
    fv_d   = 1'b0;
    fe_d   = 1'b0;
    if (bus.din_valid) begin
      if (bus.sof) begin
        // Early sof discards the partial frame; lanes keep the last good one
        fe_d   = (state_q == RUN) && (slot_q != SLOT_W'(0));
        sh0_d  = bus.din;
        slot_d = SLOT_W'(1);
      end else if (state_q == RUN) begin
        if (slot_q == SLOT_W'(0)) begin
          fe_d   = 1'b1;
          slot_d = '0;
        end else begin
          case (slot_q)
            SLOT_W'(1): sh1_d = bus.din;
            SLOT_W'(2): sh2_d = bus.din;
            default: begin
              // Slot 3 completes the frame: all four lanes move on one edge
              a_d  = sh0_q;
              b_d  = sh1_q;
              c_d  = sh2_q;
              d_d  = bus.din;
              fv_d = 1'b1;
            end
          endcase
          slot_d = slot_q + SLOT_W'(1);
        end
      end
    end
  end

  assign bus.a           = a_q;
  assign bus.b           = b_q;
  assign bus.c           = c_q;
  assign bus.d           = d_q;
  assign bus.frame_valid = fv_q;
  assign bus.frame_err   = fe_q;
  assign bus.slot        = slot_q;
  assign bus.locked      = (state_q == RUN);

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Time-division demultiplexer: the receive-side counterpart of the team's 4-to-1 channel mux (mux1b4to1).
- Accepts one serial sample stream in which slots 0..3 carry channels a, b, c and d in turn.
- Rebuilds the four parallel lanes and presents them together, once per complete frame.
- Sits at the far end of a link driven by a mux whose select cycles 00→01→10→11.

Parameters:
- WIDTH, 1, bit width of each sample and of each output lane.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- din  input  WIDTH  sample for the current slot.
- din_valid  input  1  din is valid this cycle.
- sof  input  1  start of frame; when high with din_valid, marks din as the slot-0 (channel a) sample.
- a  output  WIDTH  channel a (slot 0) of the last complete frame, registered.
- b  output  WIDTH  channel b (slot 1), registered.
- c  output  WIDTH  channel c (slot 2), registered.
- d  output  WIDTH  channel d (slot 3), registered.
- frame_valid  output  1  one-cycle pulse when a..d update.
- frame_err  output  1  one-cycle pulse on a framing error.
- slot  output  2  next expected slot index.
- locked  output  1  high while in RUN.

Behaviour:
- Reset (rst high at a clk edge):
  - a, b, c, d, shadow registers, slot = 0.
  - frame_valid, frame_err, locked = 0.
  - State = IDLE.
  - rst has priority over all inputs; asserting it mid-frame discards the partial frame.
- Sample acceptance: cycles with din_valid = 0 change nothing except clearing the pulse outputs. sof is ignored when din_valid = 0.
- FSM state IDLE (locked = 0):
  - din_valid && !sof: sample discarded, no error.
  - din_valid && sof: din → shadow[0], slot ← 1, go to RUN.
- FSM state RUN (locked = 1):
  - din_valid && !sof && slot ≠ 0: din → shadow[slot], slot ← slot + 1 (2-bit wrap, 3 → 0).
  - din_valid && !sof && slot = 3: on the same edge, a ← shadow[0], b ← shadow[1], c ← shadow[2], d ← din, and frame_valid = 1 for the following cycle.
  - din_valid && sof && slot = 0: normal frame start, as in IDLE; stay in RUN.
  - din_valid && sof && slot ≠ 0 (early sof): frame_err pulse, partial frame discarded (a..d unchanged), din → shadow[0], slot ← 1, stay in RUN (resync).
  - din_valid && !sof && slot = 0 (missing sof): frame_err pulse, sample discarded, go to IDLE, slot = 0.
- Latency: a..d and frame_valid change on the edge that accepts the slot-3 sample. Outputs are visible one cycle after that sample is presented.
- a..d always hold a coherent complete frame and never show mixed-frame data.
- frame_valid and frame_err are never high in the same cycle.
- Back-to-back frames with no idle cycles produce a frame_valid every 4th cycle.
- Gaps (din_valid = 0) inside a frame are legal and do not reset slot.

Test Plan:
1. rst 2 cycles, then sof+din 1,0,1,0 (WIDTH=1) on 4 consecutive cycles → frame_valid one cycle after the 4th sample; a=1 b=0 c=1 d=0; slot=0; locked=1.
2. Two back-to-back frames 0,1,1,1 then 1,1,0,0 with sof on the first sample of each → frame_valid exactly 4 cycles apart; final a=1 b=1 c=0 d=0.
3. Frame 1,1,0,1 with din_valid low for 2 cycles between slots 1 and 2 → same output (a=1 b=1 c=0 d=1); frame_valid once; no frame_err.
4. Early sof at slot 2, followed by a full frame 0,0,0,1 → frame_err pulse at the resync; a..d keep the previous frame until frame_valid; then d=1, a=b=c=0.
5. Missing sof: after one complete frame, a 5th sample arrives without sof → frame_err pulse, locked=0; further non-sof samples ignored; outputs hold.
6. rst asserted after slot-1 sample → next cycle slot=0, locked=0, a..d=0; a subsequent non-sof sample is ignored with no frame_err.
